// File: rtl/pe_result_drain.sv
// ---------------------------------------------------------------------------
// pe_result_drain
//   Captures NUM_MACS signed accumulator lanes from a processing element.
//   Each lane is requantized (arithmetic right shift plus saturation to
//   DATA_WIDTH) and streamed out one lane per beat on a valid/ready
//   interface. Every output comes from registered state, so there is no
//   combinational path from out_ready to any output.
//
//   Optional feature macro: DRAIN_ROUND_EN
//     defined   : round half up (add 2^(shift-1) before the shift, shift>0)
//     undefined : truncate toward negative infinity
//
// Ports
//   clk              : clock, rising edge
//   rst              : synchronous reset, active low
//   capture          : one-cycle strobe, samples mac_results_flat and shift
//   mac_results_flat : NUM_MACS lanes of 2*DATA_WIDTH signed bits, lane 0 at LSBs
//   shift            : requantization right-shift amount
//   out_data         : requantized, saturated lane value
//   out_lane         : index of the lane on out_data
//   out_valid        : beat valid
//   out_ready        : downstream ready
//   out_last         : beat carries lane NUM_MACS-1
//   out_sat          : out_data was clamped
//   busy             : draining in progress
//   overrun          : sticky, a capture arrived mid-drain and was dropped
// ---------------------------------------------------------------------------
module pe_result_drain #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_MACS   = 4,
    localparam int SHIFT_W    = $clog2(2*DATA_WIDTH),
    localparam int LANE_W     = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             capture,
    input  logic [NUM_MACS*2*DATA_WIDTH-1:0] mac_results_flat,
    input  logic [SHIFT_W-1:0]               shift,
    output logic signed [DATA_WIDTH-1:0]     out_data,
    output logic [LANE_W-1:0]                out_lane,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             out_sat,
    output logic                             busy,
    output logic                             overrun
);

    localparam int ACC_W = 2*DATA_WIDTH;
    localparam int EXT_W = ACC_W + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        {{(EXT_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [ACC_W-1:0]   r_buf [NUM_MACS];
    logic [SHIFT_W-1:0]        r_shift;
    logic [LANE_W-1:0]         r_idx;
    logic                      r_overrun;

    logic                      w_last;
    logic                      w_load;
    logic                      w_advance;
    logic                      w_ovr_set;

    logic signed [EXT_W-1:0]   w_ext;
    logic signed [EXT_W-1:0]   w_pre;
    logic signed [EXT_W-1:0]   w_shr;
    logic                      w_sat_hi;
    logic                      w_sat_lo;

    assign w_last = (r_idx == LANE_W'(NUM_MACS-1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next state and outputs ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_ovr_set   = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        out_last    = 1'b0;
        out_sat     = 1'b0;
        out_data    = '0;
        out_lane    = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (capture) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = w_last;
                out_sat   = w_sat_hi | w_sat_lo;
                out_data  = w_sat_hi ? SAT_MAX[DATA_WIDTH-1:0] :
                            w_sat_lo ? SAT_MIN[DATA_WIDTH-1:0] :
                                       w_shr[DATA_WIDTH-1:0];
                if (out_ready) begin
                    if (w_last) begin
                        // A capture on the final transfer reloads back-to-back.
                        if (capture) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_advance = 1'b1;
                        w_ovr_set = capture;
                    end
                end else begin
                    w_ovr_set = capture;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- requantization of the presented lane ----------------
    always_comb begin
        w_ext = {r_buf[r_idx][ACC_W-1], r_buf[r_idx]};
`ifdef DRAIN_ROUND_EN
        // (1 << shift) >> 1 is 2^(shift-1), and zero when shift is 0;
        // the extra sign bit keeps the sum from overflowing.
        w_pre = w_ext + $signed((EXT_W'(1) << r_shift) >> 1);
`else
        w_pre = w_ext;
`endif
        w_shr    = w_pre >>> r_shift;
        w_sat_hi = (w_shr > SAT_MAX);
        w_sat_lo = (w_shr < SAT_MIN);
    end

    // ---------------- lane buffer, index, shift, overrun ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx     <= '0;
            r_shift   <= '0;
            r_overrun <= 1'b0;
            for (int unsigned i = 0; i < NUM_MACS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
            if (w_load) begin
                for (int unsigned i = 0; i < NUM_MACS; i++) begin
                    r_buf[i] <= $signed(mac_results_flat[i*ACC_W +: ACC_W]);
                end
                r_shift <= shift;
                r_idx   <= '0;
            end else if (w_advance) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign overrun = r_overrun;

endmodule

// File: tb/tb_pe_result_drain.sv
// ---------------------------------------------------------------------------
// tb_pe_result_drain
//   Drives pe_result_drain with directed and randomized captures/backpressure.
//   A queue of expected beats, built from the lane values and shift at each
//   accepted capture, is compared against the outputs every cycle. Directed
//   cases pin exact values for the documented examples.
// ---------------------------------------------------------------------------
module tb_pe_result_drain;

    localparam int DW  = 16;
    localparam int NM  = 4;
    localparam int ACC = 2*DW;
    localparam int SW  = $clog2(2*DW);
    localparam int LNW = (NM > 1) ? $clog2(NM) : 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   capture = 1'b0;
    logic                   out_ready = 1'b0;
    logic [NM*ACC-1:0]      mac_flat = '0;
    logic [SW-1:0]          shift = '0;
    logic signed [DW-1:0]   out_data;
    logic [LNW-1:0]         out_lane;
    logic                   out_valid;
    logic                   out_last;
    logic                   out_sat;
    logic                   busy;
    logic                   overrun;

    pe_result_drain #(
        .DATA_WIDTH (DW),
        .NUM_MACS   (NM)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .capture          (capture),
        .mac_results_flat (mac_flat),
        .shift            (shift),
        .out_data         (out_data),
        .out_lane         (out_lane),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .out_sat          (out_sat),
        .busy             (busy),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        int     lane;
        bit     sat;
        bit     last;
    } beat_t;

    beat_t exp_q[$];
    beat_t log_q[$];
    bit    m_ovr = 1'b0;
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference requantization in plain integer arithmetic.
    function automatic void requant(input longint v, input int s,
                                    output longint d, output bit sat);
        longint t;
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (DW-1)) - 1;
        lo = -(64'sd1 <<< (DW-1));
        t  = v;
`ifdef DRAIN_ROUND_EN
        if (s > 0) t = t + (64'sd1 <<< (s-1));
`endif
        t   = t >>> s;
        sat = 1'b0;
        if (t > hi) begin
            d = hi; sat = 1'b1;
        end else if (t < lo) begin
            d = lo; sat = 1'b1;
        end else begin
            d = t;
        end
    endfunction

    task automatic load_set();
        logic signed [ACC-1:0] lv;
        longint d;
        bit     s;
        for (int i = 0; i < NM; i++) begin
            lv = mac_flat[i*ACC +: ACC];
            requant(longint'(lv), int'(shift), d, s);
            exp_q.push_back('{d, i, s, (i == NM-1)});
        end
    endtask

    // Behaviour at one rising edge, from the inputs presented at that edge.
    task automatic model_step();
        if (!rst) begin
            exp_q.delete();
            m_ovr = 1'b0;
        end else if (exp_q.size() == 0) begin
            if (capture) load_set();
        end else if (out_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0 && capture) load_set();
            else if (capture) m_ovr = 1'b1;
        end else if (capture) begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic check_now();
        chk("out_valid", longint'(out_valid), longint'(exp_q.size() > 0));
        chk("busy", longint'(busy), longint'(exp_q.size() > 0));
        chk("overrun", longint'(overrun), longint'(m_ovr));
        if (exp_q.size() > 0) begin
            chk("out_data", longint'(out_data), exp_q[0].data);
            chk("out_lane", longint'(out_lane), longint'(exp_q[0].lane));
            chk("out_sat", longint'(out_sat), longint'(exp_q[0].sat));
            chk("out_last", longint'(out_last), longint'(exp_q[0].last));
        end else begin
            chk("out_last_idle", longint'(out_last), 0);
        end
        if (out_valid && out_ready)
            log_q.push_back('{longint'(out_data), int'(out_lane), out_sat, out_last});
    endtask

    task automatic tick();
        @(negedge clk);
        check_now();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_lanes(input longint a, input longint b,
                             input longint c, input longint d);
        mac_flat[0*ACC +: ACC] = ACC'(a);
        mac_flat[1*ACC +: ACC] = ACC'(b);
        mac_flat[2*ACC +: ACC] = ACC'(c);
        mac_flat[3*ACC +: ACC] = ACC'(d);
    endtask

    task automatic pulse_capture();
        capture = 1'b1;
        tick();
        capture = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (out_valid && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, longint'(out_valid), 0);
    endtask

    longint e1[4]  = '{100, -200, 300, -400};
    longint e5[8]  = '{10, 20, 30, 40, 5, 6, 7, 8};

    initial begin
        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_overrun", longint'(overrun), 0);
        chk("rst_last", longint'(out_last), 0);
        chk("rst_sat", longint'(out_sat), 0);
        rst = 1'b1;
        tick();

        // Plain pass-through, full-rate drain
        log_q.delete();
        set_lanes(100, -200, 300, -400);
        shift = '0;
        out_ready = 1'b1;
        pulse_capture();
        chk("t1_valid_next", longint'(out_valid), 1);
        wait_idle("t1");
        chk("t1_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_data", log_q[i].data, e1[i]);
                chk("t1_lane", longint'(log_q[i].lane), longint'(i));
                chk("t1_last", longint'(log_q[i].last), longint'(i == 3));
            end
        end
        chk("t1_busy_after", longint'(busy), 0);

        // Saturation
        log_q.delete();
        set_lanes(70000, -70000, 0, 0);
        pulse_capture();
        wait_idle("t2");
        chk("t2_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("t2_pos_data", log_q[0].data, 32767);
            chk("t2_pos_sat", longint'(log_q[0].sat), 1);
            chk("t2_neg_data", log_q[1].data, -32768);
            chk("t2_neg_sat", longint'(log_q[1].sat), 1);
            chk("t2_zero_sat", longint'(log_q[2].sat), 0);
        end

        // Shift with rounding or truncation
        log_q.delete();
        set_lanes(6, -6, 0, 0);
        shift = SW'(2);
        pulse_capture();
        wait_idle("t3");
        chk("t3_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
`ifdef DRAIN_ROUND_EN
            chk("t3_pos", log_q[0].data, 2);
            chk("t3_neg", log_q[1].data, -1);
`else
            chk("t3_pos", log_q[0].data, 1);
            chk("t3_neg", log_q[1].data, -2);
`endif
        end
        shift = '0;

        // Backpressure on lane 1
        log_q.delete();
        set_lanes(1, 2, 3, 4);
        pulse_capture();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_lane", longint'(out_lane), 1);
            chk("t4_hold_data", longint'(out_data), 2);
            chk("t4_hold_valid", longint'(out_valid), 1);
        end
        out_ready = 1'b1;
        wait_idle("t4");
        chk("t4_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk("t4_data", log_q[i].data, longint'(i + 1));
        end

        // Overrun, then back-to-back recapture on the final transfer
        log_q.delete();
        set_lanes(10, 20, 30, 40);
        pulse_capture();
        tick();
        set_lanes(99, 99, 99, 99);
        pulse_capture();
        chk("t5_overrun", longint'(overrun), 1);
        chk("t5_lane2", longint'(out_lane), 2);
        chk("t5_data2", longint'(out_data), 30);
        tick();
        set_lanes(5, 6, 7, 8);
        pulse_capture();
        chk("t5_valid_cont", longint'(out_valid), 1);
        chk("t5_new_lane", longint'(out_lane), 0);
        chk("t5_new_data", longint'(out_data), 5);
        chk("t5_overrun_sticky", longint'(overrun), 1);
        wait_idle("t5");
        chk("t5_count", log_q.size(), 8);
        if (log_q.size() == 8) begin
            for (int i = 0; i < 8; i++)
                chk("t5_data", log_q[i].data, e5[i]);
        end

        // Reset mid-drain, capture ignored under reset
        set_lanes(1, 2, 3, 4);
        pulse_capture();
        tick();
        tick();
        chk("t6_lane2", longint'(out_lane), 2);
        rst = 1'b0;
        tick();
        chk("t6_valid", longint'(out_valid), 0);
        chk("t6_busy", longint'(busy), 0);
        chk("t6_overrun", longint'(overrun), 0);
        pulse_capture();
        chk("t6_cap_in_rst", longint'(out_valid), 0);
        rst = 1'b1;
        tick();
        chk("t6_after_rst", longint'(out_valid), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            rst       = ($urandom_range(99, 0) != 0);
            capture   = ($urandom_range(3, 0) == 0);
            out_ready = ($urandom_range(3, 0) != 0);
            shift     = SW'($urandom_range(2*DW-1, 0));
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(1, 0) == 1)
                    mac_flat[i*ACC +: ACC] = ACC'($urandom);
                else
                    mac_flat[i*ACC +: ACC] = ACC'(int'($urandom_range(200000, 0)) - 100000);
            end
            tick();
        end
        rst = 1'b1;
        capture = 1'b0;
        out_ready = 1'b1;
        wait_idle("rand");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
